hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_DIR_WIDTH, default 3, register address width.
REQ-002 SHALL have parameter LOAD_STALL, default 1, load-use stall length in cycles (legal 1..15).
REQ-003 SHALL have parameter PERF_W, default 16, stall-cycle counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, synchronous and active-high.
REQ-006 SHALL have ports IDEXRegisterRt, IFIDRegisterRs, IFIDRegisterRt  input  REG_DIR_WIDTH  destination of instruction in EX; sources of instruction in ID.
REQ-007 SHALL have port IFIDUsesRt  input  1  ID instruction reads Rt.
REQ-008 SHALL have port IDEXMemRead  input  1  instruction in EX is a load.
REQ-009 SHALL have port BranchTaken  input  1  taken branch/jump resolved in EX this cycle.
REQ-010 SHALL have port MemBusy  input  1  data memory not ready; freeze pipeline.
REQ-011 SHALL have port PerfClear  input  1  clear stall-cycle counter.
REQ-012 SHALL have outputs PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite  output  1 each  stage write enables (1 = advance).
REQ-013 SHALL have output CControl  output  1  0 = inject bubble (zero control) into ID/EX.
REQ-014 SHALL have output IFIDFlush  output  1  1 = clear IF/ID to NOP.
REQ-015 SHALL have outputs StallActive  output  1, and StallCycles  output  PERF_W  saturating count of cycles with PCWrite=0.

Function
REQ-016 SHALL compute load-use hit = IDEXMemRead and IDEXRegisterRt != 0 and (IDEXRegisterRt == IFIDRegisterRs, or IFIDUsesRt and IDEXRegisterRt == IFIDRegisterRt).
REQ-017 SHALL implement FSM states IDLE and STALL plus down-counter cnt of width sufficient for LOAD_STALL.
REQ-018 SHALL apply priority MemBusy > BranchTaken > load-use stall > normal each cycle.
REQ-019 SHALL, when MemBusy=1 in any state: PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0, CControl=1, IFIDFlush=0; state and cnt hold.
REQ-020 SHALL, when BranchTaken=1 and MemBusy=0: PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=1, IFIDFlush=1, CControl=0; next state IDLE, cnt cleared (branch cancels any pending stall).
REQ-021 SHALL, in IDLE with hit and no higher-priority event: PCWrite=IFIDWrite=0, IDEXWrite=EXMEMWrite=1, CControl=0, StallActive=1; if LOAD_STALL=1 stay IDLE, else go STALL with cnt=LOAD_STALL-1.
REQ-022 SHALL, in STALL with no higher-priority event, produce the same outputs as REQ-021 regardless of hit; decrement cnt; leave to IDLE when cnt==1 on the edge.
REQ-023 SHALL give exactly LOAD_STALL consecutive stall cycles per load-use hit absent MemBusy/BranchTaken; MemBusy cycles extend it without consuming cnt.
REQ-024 SHALL, in IDLE with no event: all write enables 1, CControl=1, IFIDFlush=0, StallActive=0.
REQ-025 SHALL drive all non-counter outputs combinationally from state and current inputs (zero-cycle latency).
REQ-026 SHALL increment StallCycles on each edge where PCWrite=0, saturating at 2^PERF_W-1; PerfClear=1 loads 0 and takes precedence over increment.
REQ-027 SHALL treat register 0 as never hazarding.

Reset
REQ-028 SHALL, while rst=1, force PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=1, CControl=1, IFIDFlush=0, StallActive=0 regardless of inputs.
REQ-029 SHALL, on edge with rst=1, set state IDLE, cnt 0, StallCycles 0; reset mid-stall aborts the stall with no residual cycles.

Verification
REQ-030 SHALL cover: LOAD_STALL=1, IDEXMemRead=1, IDEXRegisterRt=3, IFIDRegisterRs=3 -> one cycle PCWrite=IFIDWrite=CControl=0, next cycle all 1, StallCycles=1.
REQ-031 SHALL cover: LOAD_STALL=3, same hit -> PCWrite=0 for exactly 3 cycles, then IDLE; StallCycles=3.
REQ-032 SHALL cover: IDEXRegisterRt=0=IFIDRegisterRs with load, or Rt match with IFIDUsesRt=0 -> no stall.
REQ-033 SHALL cover: LOAD_STALL=3, MemBusy=1 for 2 cycles during STALL -> all write enables 0 those cycles, stall still totals 3 non-busy cycles.
REQ-034 SHALL cover: BranchTaken=1 in cycle 2 of a 3-cycle stall -> IFIDFlush=1, CControl=0, PCWrite=1, IDLE next cycle.
REQ-035 SHALL cover: rst=1 mid-stall -> outputs at reset values immediately, StallCycles=0 after edge; PERF_W=2 saturates at 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. It handles load-use stalls
//               (LOAD_STALL cycles long), memory-busy freezes and taken-branch
//               flushes, and keeps a saturating count of stalled PC cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_DIR_WIDTH = 3,
    parameter int LOAD_STALL    = 1,
    parameter int PERF_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_DIR_WIDTH-1:0] IDEXRegisterRt,
    input  logic [REG_DIR_WIDTH-1:0] IFIDRegisterRs,
    input  logic [REG_DIR_WIDTH-1:0] IFIDRegisterRt,
    input  logic                     IFIDUsesRt,
    input  logic                     IDEXMemRead,
    input  logic                     BranchTaken,
    input  logic                     MemBusy,
    input  logic                     PerfClear,
    output logic                     PCWrite,
    output logic                     IFIDWrite,
    output logic                     IDEXWrite,
    output logic                     EXMEMWrite,
    output logic                     CControl,
    output logic                     IFIDFlush,
    output logic                     StallActive,
    output logic [PERF_W-1:0]        StallCycles
);

    // The counter only needs to hold LOAD_STALL-1 (the cycles left after the
    // first stall cycle), but it is kept at least one bit wide.
    localparam int                c_CNT_W    = $clog2(LOAD_STALL + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LOAD_STALL - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [PERF_W-1:0]  c_PERF_MAX = {PERF_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t             r_state_q;
    state_t             w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;
    logic [PERF_W-1:0]  r_perf_q;
    logic [PERF_W-1:0]  w_perf_d;

    logic w_hit;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_idex_write;
    logic w_exmem_write;
    logic w_ccontrol;
    logic w_ifid_flush;
    logic w_stall_active;

    // Load-use hazard: the load in EX writes a register the ID instruction
    // reads. Register 0 is hardwired and never creates a dependency.
    assign w_hit = IDEXMemRead && (IDEXRegisterRt != '0) &&
                   ((IDEXRegisterRt == IFIDRegisterRs) ||
                    (IFIDUsesRt && (IDEXRegisterRt == IFIDRegisterRt)));

    // Next state and stage controls, in priority order reset > busy > branch > stall.
    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_pc_write     = 1'b1;
        w_ifid_write   = 1'b1;
        w_idex_write   = 1'b1;
        w_exmem_write  = 1'b1;
        w_ccontrol     = 1'b1;
        w_ifid_flush   = 1'b0;
        w_stall_active = 1'b0;

        if (rst) begin
            // Outputs stay at their free-running values; the register
            // process clears the state on the edge.
            w_state_d = IDLE;
            w_cnt_d   = '0;
        end else if (MemBusy) begin
            // Freeze every stage; a pending stall neither advances nor ends.
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_write = 1'b0;
        end else if (BranchTaken) begin
            // The wrong-path instructions are squashed, so any pending stall is moot.
            w_ifid_flush = 1'b1;
            w_ccontrol   = 1'b0;
            w_state_d    = IDLE;
            w_cnt_d      = '0;
        end else if (r_state_q == STALL) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_ccontrol     = 1'b0;
            w_stall_active = 1'b1;
            w_cnt_d        = r_cnt_q - c_CNT_ONE;
            w_state_d      = (r_cnt_q == c_CNT_ONE) ? IDLE : STALL;
        end else if (w_hit) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_ccontrol     = 1'b0;
            w_stall_active = 1'b1;
            // The current cycle is the first stall cycle, so only
            // LOAD_STALL-1 cycles remain to be counted in STALL.
            if (LOAD_STALL > 1) begin
                w_state_d = STALL;
                w_cnt_d   = c_CNT_LOAD;
            end
        end
    end

    // Stall-cycle counter: clear wins over increment, and the count saturates.
    always_comb begin
        w_perf_d = r_perf_q;
        if (PerfClear) begin
            w_perf_d = '0;
        end else if (!w_pc_write && (r_perf_q != c_PERF_MAX)) begin
            w_perf_d = r_perf_q + PERF_W'(1);
        end
    end

    // State, stall counter and performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_cnt_q   <= '0;
            r_perf_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_perf_q  <= w_perf_d;
        end
    end

    assign PCWrite     = w_pc_write;
    assign IFIDWrite   = w_ifid_write;
    assign IDEXWrite   = w_idex_write;
    assign EXMEMWrite  = w_exmem_write;
    assign CControl    = w_ccontrol;
    assign IFIDFlush   = w_ifid_flush;
    assign StallActive = w_stall_active;
    assign StallCycles = r_perf_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances share the
//               stimulus: LOAD_STALL=1/PERF_W=16 and LOAD_STALL=3/PERF_W=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    // Output vectors are packed as {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
    // CControl, IFIDFlush, StallActive}.
    localparam logic [6:0] c_NORM  = 7'b1111_1_0_0;
    localparam logic [6:0] c_STALL = 7'b0011_0_0_1;
    localparam logic [6:0] c_BUSY  = 7'b0000_1_0_0;
    localparam logic [6:0] c_BR    = 7'b1111_0_1_0;

    logic       clk = 1'b0;
    logic       rst, memrd, uses, br, busy, pclr;
    logic [2:0] exrt, rs, idrt;

    logic        pc1, ifid1, idex1, exmem1, cc1, fl1, sa1;
    logic        pc3, ifid3, idex3, exmem3, cc3, fl3, sa3;
    logic [15:0] perf1;
    logic [1:0]  perf3;
    logic [6:0]  o1v, o3v;

    assign o1v = {pc1, ifid1, idex1, exmem1, cc1, fl1, sa1};
    assign o3v = {pc3, ifid3, idex3, exmem3, cc3, fl3, sa3};

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_DIR_WIDTH(3), .LOAD_STALL(1), .PERF_W(16)) u1 (
        .clk(clk), .rst(rst),
        .IDEXRegisterRt(exrt), .IFIDRegisterRs(rs), .IFIDRegisterRt(idrt),
        .IFIDUsesRt(uses), .IDEXMemRead(memrd), .BranchTaken(br),
        .MemBusy(busy), .PerfClear(pclr),
        .PCWrite(pc1), .IFIDWrite(ifid1), .IDEXWrite(idex1), .EXMEMWrite(exmem1),
        .CControl(cc1), .IFIDFlush(fl1), .StallActive(sa1), .StallCycles(perf1)
    );

    hazard_ctrl #(.REG_DIR_WIDTH(3), .LOAD_STALL(3), .PERF_W(2)) u3 (
        .clk(clk), .rst(rst),
        .IDEXRegisterRt(exrt), .IFIDRegisterRs(rs), .IFIDRegisterRt(idrt),
        .IFIDUsesRt(uses), .IDEXMemRead(memrd), .BranchTaken(br),
        .MemBusy(busy), .PerfClear(pclr),
        .PCWrite(pc3), .IFIDWrite(ifid3), .IDEXWrite(idex3), .EXMEMWrite(exmem3),
        .CControl(cc3), .IFIDFlush(fl3), .StallActive(sa3), .StallCycles(perf3)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: stall cycles still owed and stalled-cycle count per DUT.
    int rem[2]  = '{0, 0};
    int perf[2] = '{0, 0};
    int ls[2]   = '{1, 3};
    int pmax[2] = '{65535, 3};

    logic [6:0] s_u1, s_u3;
    int         pc0_u1, pc0_u3;

    typedef struct {
        logic       rst, memrd;
        logic [2:0] exrt, rs, idrt;
        logic       uses, br, busy;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic model_hit();
        return memrd && (exrt != 0) && ((exrt == rs) || (uses && (exrt == idrt)));
    endfunction

    function automatic logic [6:0] model_out(input int d);
        if (rst)                        return c_NORM;
        if (busy)                       return c_BUSY;
        if (br)                         return c_BR;
        if ((rem[d] > 0) || model_hit()) return c_STALL;
        return c_NORM;
    endfunction

    task automatic drive(input logic r, input logic m, input logic [2:0] e,
                         input logic [2:0] s, input logic [2:0] t,
                         input logic u, input logic b, input logic y);
        rst = r; memrd = m; exrt = e; rs = s; idrt = t;
        uses = u; br = b; busy = y; pclr = 1'b0;
    endtask

    // One clock: compare both DUTs with the model mid-cycle, then advance the model.
    task automatic cycle();
        logic [6:0] e[2];
        logic       h;
        @(negedge clk);
        h = model_hit();
        for (int d = 0; d < 2; d++) e[d] = model_out(d);
        chk("outs_u1", int'(o1v), int'(e[0]));
        chk("outs_u3", int'(o3v), int'(e[1]));
        chk("perf_u1", int'(perf1), perf[0]);
        chk("perf_u3", int'(perf3), perf[1]);
        s_u1 = o1v;
        s_u3 = o3v;
        if (!o1v[6]) pc0_u1++;
        if (!o3v[6]) pc0_u3++;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                rem[d] = 0;
                perf[d] = 0;
            end else begin
                if (busy)             ;
                else if (br)          rem[d] = 0;
                else if (rem[d] > 0)  rem[d] = rem[d] - 1;
                else if (h)           rem[d] = ls[d] - 1;
                if (pclr)                                  perf[d] = 0;
                else if (!e[d][6] && (perf[d] < pmax[d]))  perf[d] = perf[d] + 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        pc0_u1 = 0;
        pc0_u3 = 0;
    endtask

    task automatic hit_cyc();
        drive(0, 1, 3'd3, 3'd3, 3'd0, 0, 0, 0);
        cycle();
    endtask

    task automatic idle_cyc();
        drive(0, 0, 3'd0, 3'd1, 3'd2, 0, 0, 0);
        cycle();
    endtask

    initial begin
        tbl[0] = '{1, 1, 3'd3, 3'd3, 3'd0, 0, 1, 1, c_NORM};
        tbl[1] = '{0, 1, 3'd3, 3'd3, 3'd0, 0, 0, 0, c_STALL};
        tbl[2] = '{0, 0, 3'd3, 3'd3, 3'd0, 0, 0, 0, c_NORM};
        tbl[3] = '{0, 1, 3'd0, 3'd0, 3'd0, 1, 0, 0, c_NORM};
        tbl[4] = '{0, 1, 3'd5, 3'd1, 3'd5, 0, 0, 0, c_NORM};
        tbl[5] = '{0, 1, 3'd5, 3'd1, 3'd5, 1, 0, 0, c_STALL};
        tbl[6] = '{0, 1, 3'd5, 3'd5, 3'd0, 0, 1, 0, c_BR};
        tbl[7] = '{0, 1, 3'd5, 3'd5, 3'd0, 0, 1, 1, c_BUSY};
        tbl[8] = '{0, 1, 3'd2, 3'd7, 3'd4, 1, 0, 0, c_NORM};
        tbl[9] = '{0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, c_BUSY};

        pc0_u1 = 0;
        pc0_u3 = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Single-cycle-stall instance against hand-written expectations.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rst, tbl[i].memrd, tbl[i].exrt, tbl[i].rs, tbl[i].idrt,
                  tbl[i].uses, tbl[i].br, tbl[i].busy);
            cycle();
            chk($sformatf("tbl_%0d", i), int'(s_u1), int'(tbl[i].exp));
        end

        // One hit: one stalled cycle for LOAD_STALL=1, three for LOAD_STALL=3.
        do_reset();
        hit_cyc();
        chk("ls1_hit", int'(s_u1), int'(c_STALL));
        idle_cyc();
        chk("ls1_after", int'(s_u1), int'(c_NORM));
        chk("ls3_second", int'(s_u3), int'(c_STALL));
        repeat (3) idle_cyc();
        chk("ls3_tail", int'(s_u3), int'(c_NORM));
        chk("ls1_pc0_count", pc0_u1, 1);
        chk("ls3_pc0_count", pc0_u3, 3);
        chk("ls1_perf", int'(perf1), 1);
        chk("ls3_perf", int'(perf3), 3);

        // MemBusy inside a stall freezes it without using up stall cycles.
        do_reset();
        hit_cyc();
        idle_cyc();
        drive(0, 0, 3'd0, 3'd1, 3'd2, 0, 0, 1);
        cycle();
        chk("busy1_u3", int'(s_u3), int'(c_BUSY));
        cycle();
        chk("busy2_u3", int'(s_u3), int'(c_BUSY));
        idle_cyc();
        chk("busy_resume_u3", int'(s_u3), int'(c_STALL));
        idle_cyc();
        chk("busy_end_u3", int'(s_u3), int'(c_NORM));
        chk("busy_pc0_u3", pc0_u3, 5);
        chk("busy_perf_sat_u3", int'(perf3), 3);
        chk("busy_perf_u1", int'(perf1), 3);

        // A taken branch in the second stall cycle cancels the remainder.
        do_reset();
        hit_cyc();
        drive(0, 0, 3'd0, 3'd1, 3'd2, 0, 1, 0);
        cycle();
        chk("br_in_stall_u3", int'(s_u3), int'(c_BR));
        idle_cyc();
        chk("br_after_u3", int'(s_u3), int'(c_NORM));

        // Reset during a stall takes effect on the outputs at once.
        do_reset();
        hit_cyc();
        drive(1, 1, 3'd3, 3'd3, 3'd0, 0, 0, 1);
        cycle();
        chk("rst_mid_u3", int'(s_u3), int'(c_NORM));
        chk("rst_perf_u3", int'(perf3), 0);
        chk("rst_perf_u1", int'(perf1), 0);
        idle_cyc();
        chk("rst_after_u3", int'(s_u3), int'(c_NORM));

        // Clear beats increment even while stalled.
        do_reset();
        hit_cyc();
        drive(0, 0, 3'd0, 3'd1, 3'd2, 0, 0, 0);
        pclr = 1'b1;
        cycle();
        chk("pclr_u3", int'(perf3), 0);
        idle_cyc();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 31) == 0);
            memrd = $urandom_range(0, 1);
            exrt  = 3'($urandom_range(0, 3));
            rs    = 3'($urandom_range(0, 3));
            idrt  = 3'($urandom_range(0, 3));
            uses  = $urandom_range(0, 1);
            br    = ($urandom_range(0, 7) == 0);
            busy  = ($urandom_range(0, 7) == 0);
            pclr  = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
